// File: rtl/text_scanline_fetcher.sv
// -----------------------------------------------------------------------------
// text_scanline_fetcher
//
// Fetches the font glyph slices for one text-mode scanline during horizontal
// blanking and plays them out as a 1-bit pixel stream during active video.
// A ping-pong line buffer lets the next line be fetched while the current
// line is being serialized.
//
// Fetch pipeline for column k, counted in clock edges from the accept edge 0:
//   edge k   : TXT_ADDR = base + k
//   edge k+1 : text RAM returns the character code
//   edge k+2 : CHAR_OUT <= TXT_DATA (the font ROM updates on the falling edge)
//   edge k+3 : FONT_DATA is written into back buffer slot k
//
// Optional build macro: TEXT_CURSOR_EN adds an underline-block cursor. The
// slice captured for the cursor cell is inverted on glyph rows 14 and 15.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   LINE_REQ, SCAN_Y  one-cycle fetch request for pixel row SCAN_Y
//   TXT_ADDR/TXT_DATA text RAM read port (synchronous RAM, 1-cycle latency)
//   CHAR_OUT/ROW_OUT  font ROM character code and glyph row
//   FONT_DATA         font ROM row data, bit 0 is the leftmost pixel
//   FETCH_BUSY        fetch in progress (FETCH or DRAIN)
//   FETCH_DONE        one-cycle pulse: back buffer complete
//   PIX_START         pulse one cycle before the first active pixel
//   PIX_EN            pixel strobe during active video
//   PIXEL             registered serialized pixel
//   OVERRUN           sticky: a LINE_REQ was rejected
//   UNDERRUN          sticky: PIX_START found no completed buffer
//   CURSOR_ON/COL/ROW cursor control (only with TEXT_CURSOR_EN)
// -----------------------------------------------------------------------------
module text_scanline_fetcher #(
    parameter int COLS    = 64,
    parameter int GLYPH_W = 10,
    parameter int GLYPH_H = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        LINE_REQ,
    input  logic [8:0]                  SCAN_Y,
    output logic [ADDR_W-1:0]           TXT_ADDR,
    input  logic [7:0]                  TXT_DATA,
    output logic [7:0]                  CHAR_OUT,
    output logic [$clog2(GLYPH_H)-1:0]  ROW_OUT,
    input  logic [GLYPH_W-1:0]          FONT_DATA,
    output logic                        FETCH_BUSY,
    output logic                        FETCH_DONE,
    input  logic                        PIX_START,
    input  logic                        PIX_EN,
`ifdef TEXT_CURSOR_EN
    input  logic                        CURSOR_ON,
    input  logic [5:0]                  CURSOR_COL,
    input  logic [4:0]                  CURSOR_ROW,
`endif
    output logic                        PIXEL,
    output logic                        OVERRUN,
    output logic                        UNDERRUN
);

    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int CNT_W = $clog2(COLS + 4);
    localparam int COL_W = $clog2(COLS);
    localparam int BIT_W = $clog2(GLYPH_W);

    // Fetch counter value seen at the edge that produces each pipeline event.
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST_CHAR = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] CNT_LAST_CAP  = CNT_W'(COLS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE      = CNT_W'(COLS + 2);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(COLS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(GLYPH_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Fetch side
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         char_q, char_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [4:0]         trow_q, trow_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               accept;
    logic               cap_en;
    logic [COL_W-1:0]   cap_col;
    logic [GLYPH_W-1:0] cap_data;

    // Buffer handshake and serializer side
    logic               ready_q, ready_d;
    logic               wsel_q, wsel_d;
    logic               front_q, front_d;
    logic               fvalid_q, fvalid_d;
    logic               und_q, und_d;
    logic [COL_W-1:0]   scol_q, scol_d;
    logic [BIT_W-1:0]   sbit_q, sbit_d;
    logic               send_q, send_d;
    logic               pix_q, pix_d;
    logic [GLYPH_W-1:0] rd_slice;

    // Ping-pong line buffer: [buffer select][column]
    logic [GLYPH_W-1:0] line_q [2][COLS];

    // -------------------------------------------------------------------------
    // Fetch FSM: next state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        char_d  = char_q;
        row_d   = row_q;
        trow_d  = trow_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        cap_en  = 1'b0;
        cap_col = '0;
        accept  = LINE_REQ && (state_q == IDLE) && !ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    trow_d  = SCAN_Y[8:4];
                    row_d   = SCAN_Y[3:0];
                    // Row base wraps at ADDR_W bits.
                    addr_d  = ADDR_W'(SCAN_Y[8:4]) * ADDR_W'(COLS);
                end
            end
            FETCH, DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q < CNT_LAST_ADDR) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if ((cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_LAST_CHAR)) begin
                    char_d = TXT_DATA;
                end
                if ((cnt_q >= CNT_W'(2)) && (cnt_q <= CNT_LAST_CAP)) begin
                    cap_en  = 1'b1;
                    cap_col = COL_W'(cnt_q - CNT_W'(2));
                end
                if (cnt_q == CNT_LAST_ADDR) begin
                    state_d = DRAIN;
                end
                if (cnt_q == CNT_DONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (LINE_REQ && !accept) begin
            ovr_d = 1'b1;
        end
    end

    // Slice written into the back buffer, optionally inverted for the cursor.
    always_comb begin
`ifdef TEXT_CURSOR_EN
        if (CURSOR_ON && (trow_q == CURSOR_ROW) && (cap_col == CURSOR_COL) &&
            (row_q >= ROW_W'(14))) begin
            cap_data = ~FONT_DATA;
        end else begin
            cap_data = FONT_DATA;
        end
`else
        cap_data = FONT_DATA;
`endif
    end

    // -------------------------------------------------------------------------
    // Buffer swap and serializer
    // -------------------------------------------------------------------------
    assign rd_slice = line_q[front_q][scol_q];

    always_comb begin
        ready_d  = ready_q;
        wsel_d   = wsel_q;
        front_d  = front_q;
        fvalid_d = fvalid_q;
        und_d    = und_q;
        scol_d   = scol_q;
        sbit_d   = sbit_q;
        send_d   = send_q;
        pix_d    = pix_q;

        if (PIX_START) begin
            scol_d = '0;
            sbit_d = '0;
            send_d = 1'b0;
            if (ready_q) begin
                front_d  = wsel_q;
                wsel_d   = ~wsel_q;
                ready_d  = 1'b0;
                fvalid_d = 1'b1;
            end else begin
                fvalid_d = 1'b0;
                und_d    = 1'b1;
            end
        end else if (PIX_EN) begin
            pix_d = (fvalid_q && !send_q) ? rd_slice[sbit_q] : 1'b0;
            if (!send_q) begin
                if (sbit_q == BIT_LAST) begin
                    sbit_d = '0;
                    scol_d = scol_q + COL_W'(1);
                    if (scol_q == COL_LAST) begin
                        send_d = 1'b1;
                    end
                end else begin
                    sbit_d = sbit_q + BIT_W'(1);
                end
            end
        end

        // A fetch only starts with READY=0, so completion never collides with a swap.
        if (done_d) begin
            ready_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            char_q   <= '0;
            row_q    <= '0;
            trow_q   <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ready_q  <= 1'b0;
            wsel_q   <= 1'b0;
            front_q  <= 1'b0;
            fvalid_q <= 1'b0;
            und_q    <= 1'b0;
            scol_q   <= '0;
            sbit_q   <= '0;
            send_q   <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            char_q   <= char_d;
            row_q    <= row_d;
            trow_q   <= trow_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            ready_q  <= ready_d;
            wsel_q   <= wsel_d;
            front_q  <= front_d;
            fvalid_q <= fvalid_d;
            und_q    <= und_d;
            scol_q   <= scol_d;
            sbit_q   <= sbit_d;
            send_q   <= send_d;
            pix_q    <= pix_d;
        end
    end

    // NOTE: the line buffer has no reset; FRONT_VALID gates any stale contents.
    always_ff @(posedge CLK) begin
        if (cap_en) begin
            line_q[wsel_q][cap_col] <= cap_data;
        end
    end

    assign TXT_ADDR   = addr_q;
    assign CHAR_OUT   = char_q;
    assign ROW_OUT    = row_q;
    assign FETCH_BUSY = (state_q != IDLE);
    assign FETCH_DONE = done_q;
    assign PIXEL      = pix_q;
    assign OVERRUN    = ovr_q;
    assign UNDERRUN   = und_q;

endmodule

// File: tb/tb_text_scanline_fetcher.sv
// -----------------------------------------------------------------------------
// Testbench for text_scanline_fetcher: models the text RAM (synchronous read)
// and the font ROM (updates on the falling edge), then runs directed scenarios
// with expected values derived from those memory contents.
// -----------------------------------------------------------------------------
module tb_text_scanline_fetcher;

    localparam int ADDR_W = 11;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              LINE_REQ = 1'b0;
    logic [8:0]        SCAN_Y = '0;
    logic [ADDR_W-1:0] TXT_ADDR;
    logic [7:0]        TXT_DATA = '0;
    logic [7:0]        CHAR_OUT;
    logic [3:0]        ROW_OUT;
    logic [9:0]        FONT_DATA = '0;
    logic              FETCH_BUSY;
    logic              FETCH_DONE;
    logic              PIX_START = 1'b0;
    logic              PIX_EN = 1'b0;
    logic              PIXEL;
    logic              OVERRUN;
    logic              UNDERRUN;
`ifdef TEXT_CURSOR_EN
    logic              CURSOR_ON = 1'b0;
    logic [5:0]        CURSOR_COL = '0;
    logic [4:0]        CURSOR_ROW = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [2048];

    text_scanline_fetcher dut (
        .CLK        (CLK),
        .RST        (RST),
        .LINE_REQ   (LINE_REQ),
        .SCAN_Y     (SCAN_Y),
        .TXT_ADDR   (TXT_ADDR),
        .TXT_DATA   (TXT_DATA),
        .CHAR_OUT   (CHAR_OUT),
        .ROW_OUT    (ROW_OUT),
        .FONT_DATA  (FONT_DATA),
        .FETCH_BUSY (FETCH_BUSY),
        .FETCH_DONE (FETCH_DONE),
        .PIX_START  (PIX_START),
        .PIX_EN     (PIX_EN),
`ifdef TEXT_CURSOR_EN
        .CURSOR_ON  (CURSOR_ON),
        .CURSOR_COL (CURSOR_COL),
        .CURSOR_ROW (CURSOR_ROW),
`endif
        .PIXEL      (PIXEL),
        .OVERRUN    (OVERRUN),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    // Font contents: 0x48 row 3 is the hand-picked pattern, the rest is a mix.
    function automatic logic [9:0] font(input logic [7:0] c, input logic [3:0] r);
        if (c == 8'h48 && r == 4'd3) return 10'b0000100001;
        return {r[1:0], c} ^ {c[3:0], r, 2'b10};
    endfunction

    always @(posedge CLK) TXT_DATA  <= mem[TXT_ADDR];
    always @(negedge CLK) FONT_DATA <= font(CHAR_OUT, ROW_OUT);

    task automatic do_reset();
        RST = 1'b1;
        LINE_REQ = 1'b0;
        PIX_START = 1'b0;
        PIX_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({TXT_ADDR, CHAR_OUT, ROW_OUT, FETCH_BUSY, FETCH_DONE, PIXEL, OVERRUN, UNDERRUN} !== '0) begin
            $display("FAIL reset_outputs: addr=%0d char=%h row=%0d busy=%b done=%b pix=%b ovr=%b und=%b, want all 0",
                     TXT_ADDR, CHAR_OUT, ROW_OUT, FETCH_BUSY, FETCH_DONE, PIXEL, OVERRUN, UNDERRUN);
            n_fail++;
        end
    endtask

    // Full fetch with per-edge checks. req_at/pix_at inject a LINE_REQ or
    // PIX_START at that edge number (0 = none).
    task automatic run_fetch(input logic [8:0] sy, input int req_at, input int pix_at);
        int base;
        base = int'(sy[8:4]) * 64;
        SCAN_Y = sy;
        LINE_REQ = 1'b1;
        @(posedge CLK);
        #1;
        LINE_REQ = 1'b0;
        n_tests++;
        if (ROW_OUT !== sy[3:0] || TXT_ADDR !== ADDR_W'(base) || FETCH_BUSY !== 1'b1) begin
            $display("FAIL fetch_accept: row=%0d addr=%0d busy=%b, want row=%0d addr=%0d busy=1",
                     ROW_OUT, TXT_ADDR, FETCH_BUSY, sy[3:0], base);
            n_fail++;
        end
        for (int t = 1; t <= 68; t++) begin
            LINE_REQ  = (t == req_at);
            SCAN_Y    = (t == req_at) ? 9'h1FF : sy;
            PIX_START = (t == pix_at);
            @(posedge CLK);
            #1;
            LINE_REQ  = 1'b0;
            PIX_START = 1'b0;
            SCAN_Y    = sy;
            if (t <= 63) begin
                n_tests++;
                if (TXT_ADDR !== ADDR_W'(base + t)) begin
                    $display("FAIL fetch_addr edge %0d: got %0d, want %0d", t, TXT_ADDR, base + t);
                    n_fail++;
                end
            end
            if (t >= 2 && t <= 65) begin
                n_tests++;
                if (CHAR_OUT !== mem[base + t - 2]) begin
                    $display("FAIL fetch_char edge %0d: got %h, want %h", t, CHAR_OUT, mem[base + t - 2]);
                    n_fail++;
                end
            end
            n_tests++;
            if (FETCH_DONE !== (t == 67) || FETCH_BUSY !== (t < 67)) begin
                $display("FAIL fetch_ctrl edge %0d: done=%b busy=%b, want done=%b busy=%b",
                         t, FETCH_DONE, FETCH_BUSY, (t == 67), (t < 67));
                n_fail++;
            end
        end
        n_tests++;
        if (ROW_OUT !== sy[3:0] || TXT_ADDR !== ADDR_W'(base + 63) || CHAR_OUT !== mem[base + 63] ||
            OVERRUN !== (req_at != 0)) begin
            $display("FAIL fetch_hold: row=%0d addr=%0d char=%h ovr=%b, want row=%0d addr=%0d char=%h ovr=%b",
                     ROW_OUT, TXT_ADDR, CHAR_OUT, OVERRUN, sy[3:0], base + 63, mem[base + 63], (req_at != 0));
            n_fail++;
        end
    endtask

    // Serialize one completed line; PIX_EN drops for three cycles after the
    // sixth pixel to check that PIXEL holds.
    task automatic test_pixels(input logic [8:0] sy, input logic inv0, input logic exp_und);
        int base;
        int idx;
        logic [9:0] slice;
        logic [9:0] first10;
        logic exp_pix;
        logic en;
        base = int'(sy[8:4]) * 64;
        first10 = '0;
        exp_pix = 1'b0;
        idx = 0;
        PIX_START = 1'b1;
        @(posedge CLK);
        #1;
        PIX_START = 1'b0;
        n_tests++;
        if (UNDERRUN !== exp_und) begin
            $display("FAIL pix_start_underrun: got %b, want %b", UNDERRUN, exp_und);
            n_fail++;
        end
        for (int i = 0; i < 660; i++) begin
            en = !(i >= 6 && i < 9);
            PIX_EN = en;
            @(posedge CLK);
            #1;
            PIX_EN = 1'b0;
            if (en) begin
                if (idx < 640) begin
                    slice = font(mem[base + idx / 10], sy[3:0]);
                    if (inv0 && (idx / 10) == 0) slice = ~slice;
                    exp_pix = slice[idx % 10];
                end else begin
                    exp_pix = 1'b0;
                end
                if (idx < 10) first10[idx] = PIXEL;
                idx++;
            end
            n_tests++;
            if (PIXEL !== exp_pix) begin
                $display("FAIL pixel line %h step %0d (pixel %0d): got %b, want %b", sy, i, idx - 1, PIXEL, exp_pix);
                n_fail++;
            end
        end
        if (sy == 9'h023 && !inv0) begin
            n_tests++;
            if (first10 !== 10'b0000100001) begin
                $display("FAIL first_10_pixels: got %b, want %b (bit0 first)", first10, 10'b0000100001);
                n_fail++;
            end
        end
    endtask

    task automatic test_fetch_and_pixels();
        do_reset();
        run_fetch(9'h023, 0, 0);
        test_pixels(9'h023, 1'b0, 1'b0);
        // Second line lands in the other buffer half.
        run_fetch(9'h1F5, 0, 0);
        test_pixels(9'h1F5, 1'b0, 1'b0);
    endtask

    task automatic test_overrun_busy();
        do_reset();
        run_fetch(9'h023, 30, 0);
        test_pixels(9'h023, 1'b0, 1'b0);
    endtask

    task automatic test_overrun_ready();
        do_reset();
        run_fetch(9'h023, 0, 0);
        SCAN_Y = 9'h045;
        LINE_REQ = 1'b1;
        @(posedge CLK);
        #1;
        LINE_REQ = 1'b0;
        n_tests++;
        if (OVERRUN !== 1'b1 || FETCH_BUSY !== 1'b0 || ROW_OUT !== 4'd3 || TXT_ADDR !== 11'd191) begin
            $display("FAIL overrun_ready: ovr=%b busy=%b row=%0d addr=%0d, want ovr=1 busy=0 row=3 addr=191",
                     OVERRUN, FETCH_BUSY, ROW_OUT, TXT_ADDR);
            n_fail++;
        end
        test_pixels(9'h023, 1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        int ones;
        do_reset();
        PIX_START = 1'b1;
        @(posedge CLK);
        #1;
        PIX_START = 1'b0;
        n_tests++;
        if (UNDERRUN !== 1'b1 || OVERRUN !== 1'b0) begin
            $display("FAIL underrun_flag: und=%b ovr=%b, want und=1 ovr=0", UNDERRUN, OVERRUN);
            n_fail++;
        end
        ones = 0;
        PIX_EN = 1'b1;
        repeat (640) begin
            @(posedge CLK);
            #1;
            if (PIXEL !== 1'b0) ones++;
        end
        PIX_EN = 1'b0;
        n_tests++;
        if (ones != 0) begin
            $display("FAIL underrun_pixels: %0d non-zero pixels, want 0", ones);
            n_fail++;
        end
    endtask

    // PIX_START on the FETCH_DONE edge underruns; the completed buffer is
    // still available to the following PIX_START.
    task automatic test_done_collision();
        do_reset();
        run_fetch(9'h023, 0, 67);
        n_tests++;
        if (UNDERRUN !== 1'b1) begin
            $display("FAIL done_collision_underrun: got %b, want 1", UNDERRUN);
            n_fail++;
        end
        test_pixels(9'h023, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_fetch();
        int seen;
        do_reset();
        SCAN_Y = 9'h023;
        LINE_REQ = 1'b1;
        @(posedge CLK);
        #1;
        LINE_REQ = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_tests++;
        if ({TXT_ADDR, CHAR_OUT, ROW_OUT, FETCH_BUSY, FETCH_DONE, PIXEL, OVERRUN, UNDERRUN} !== '0) begin
            $display("FAIL mid_reset_outputs: addr=%0d char=%h row=%0d busy=%b done=%b, want all 0",
                     TXT_ADDR, CHAR_OUT, ROW_OUT, FETCH_BUSY, FETCH_DONE);
            n_fail++;
        end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        seen = 0;
        repeat (45) begin
            @(posedge CLK);
            #1;
            if (FETCH_DONE === 1'b1 || FETCH_BUSY === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            $display("FAIL mid_reset_no_done: %0d cycles with done/busy after abort, want 0", seen);
            n_fail++;
        end
        run_fetch(9'h023, 0, 0);
        test_pixels(9'h023, 1'b0, 1'b0);
    endtask

`ifdef TEXT_CURSOR_EN
    task automatic test_cursor();
        do_reset();
        CURSOR_ON  = 1'b1;
        CURSOR_COL = 6'd0;
        CURSOR_ROW = 5'd2;
        run_fetch(9'h02E, 0, 0);
        test_pixels(9'h02E, 1'b1, 1'b0);
        do_reset();
        run_fetch(9'h02D, 0, 0);
        test_pixels(9'h02D, 1'b0, 1'b0);
        CURSOR_ON = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[128] = 8'h48;

        test_reset();
        test_fetch_and_pixels();
        test_overrun_busy();
        test_overrun_ready();
        test_underrun();
        test_done_collision();
        test_reset_mid_fetch();
`ifdef TEXT_CURSOR_EN
        test_cursor();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
